// File: rtl/data_multiplexer.sv
// Packet-granular round-robin merge of NUM_STREAMS ndata streams onto one output,
// emitting one source-index token per granted packet for the downstream demultiplexer.
module data_multiplexer #(
    parameter int NUM_STREAMS  = 4,
    parameter int ELEM_W       = 8,
    parameter int NUM_ELEMENTS = 2,
    parameter int SEL_W        = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
    parameter int DATA_W       = ELEM_W * NUM_ELEMENTS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_STREAMS*DATA_W-1:0]       in_data,
    input  logic [NUM_STREAMS*NUM_ELEMENTS-1:0] in_keep,
    input  logic [NUM_STREAMS-1:0]              in_last,
    input  logic [NUM_STREAMS-1:0]              in_valid,
    output logic [NUM_STREAMS-1:0]              in_ready,
    output logic [DATA_W-1:0]                   out_data,
    output logic [NUM_ELEMENTS-1:0]             out_keep,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SEL_W-1:0]                    select_data,
    output logic                                select_valid,
    input  logic                                select_ready,
    output logic                                dbg_locked
);
    // Handshakes: a beat or token moves on a rising edge where valid && ready are both high.

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(NUM_STREAMS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_STREAMS - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             sel_pending_q, sel_pending_d;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] cand;
    logic [SEL_W:0]   sum;
    logic             any_valid;
    logic             locked;

    assign locked       = (state_q == LOCKED);
    assign dbg_locked   = locked;
    assign select_valid = sel_pending_q;
    assign select_data  = grant_q;

    // Scan downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            cand = sum[SEL_W-1:0];
            if (in_valid[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        out_data  = '0;
        out_keep  = '0;
        out_last  = 1'b0;
        out_valid = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (locked && (grant_q == SEL_W'(i))) begin
                out_data    = in_data[i*DATA_W +: DATA_W];
                out_keep    = in_keep[i*NUM_ELEMENTS +: NUM_ELEMENTS];
                out_last    = in_last[i];
                out_valid   = in_valid[i];
                in_ready[i] = out_ready;
            end
        end
    end

    // A grant is only possible with no token outstanding, so it never collides with a token handshake.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        sel_pending_d = sel_pending_q;
        if (sel_pending_q && select_ready) begin
            sel_pending_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (!sel_pending_q && any_valid) begin
                    grant_d       = winner;
                    sel_pending_d = 1'b1;
                    state_d       = LOCKED;
                end
            end
            LOCKED: begin
                if (out_valid && out_ready && out_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + SEL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            sel_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            sel_pending_q <= sel_pending_d;
        end
    end

endmodule

// File: tb/tb_data_multiplexer.sv
// Directed bench for data_multiplexer: expected beats and tokens are queued by hand
// in arbitration order and checked by a monitor as the DUT hands them over.
module tb_data_multiplexer;
    localparam int N      = 4;
    localparam int ELEM_W = 8;
    localparam int NE     = 2;
    localparam int DW     = ELEM_W * NE;
    localparam int SEL_W  = 2;
    localparam int W      = DW + NE + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*DW-1:0]   in_data  = '0;
    logic [N*NE-1:0]   in_keep  = '0;
    logic [N-1:0]      in_last  = '0;
    logic [N-1:0]      in_valid = '0;
    logic [N-1:0]      in_ready;
    logic [DW-1:0]     out_data;
    logic [NE-1:0]     out_keep;
    logic              out_last;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [SEL_W-1:0]  select_data;
    logic              select_valid;
    logic              select_ready = 1'b1;
    logic              dbg_locked;

    logic [W-1:0]      exp_q[$];
    logic [SEL_W-1:0]  exp_sel_q[$];
    logic [W-1:0]      src_q[N][$];
    logic [N-1:0]      src_en = '0;
    logic [N-1:0]      hs = '0;
    logic              rand_ready = 1'b0;
    logic              out_ready_fix = 1'b1;
    logic [W-1:0]      exp_b;
    logic [SEL_W-1:0]  exp_s;
    int                checks = 0;
    int                errors = 0;
    int                beat_cnt = 0;
    int                cyc = 0;
    int                hs_cyc_q[$];

    data_multiplexer #(
        .NUM_STREAMS (N),
        .ELEM_W      (ELEM_W),
        .NUM_ELEMENTS(NE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_keep     (in_keep),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_keep    (out_keep),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .select_data (select_data),
        .select_valid(select_valid),
        .select_ready(select_ready),
        .dbg_locked  (dbg_locked)
    );

    // ---------------- clock / reset ----------------
    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- drivers ----------------
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && src_q[i].size() > 0) src_q[i].delete(0);
            if (src_en[i] && src_q[i].size() > 0) begin
                {in_data[i*DW +: DW], in_keep[i*NE +: NE], in_last[i]} = src_q[i][0];
                in_valid[i] = 1'b1;
            end else begin
                {in_data[i*DW +: DW], in_keep[i*NE +: NE], in_last[i]} = '0;
                in_valid[i] = 1'b0;
            end
        end
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : out_ready_fix;
    end

    function automatic logic [W-1:0] mk_beat(int s, int tag, int k, int n);
        logic [DW-1:0] d;
        logic [NE-1:0] kp;
        logic          l;
        d  = {4'(s), 4'(tag), 8'(k)};
        kp = (k == n - 1 && (n % 2) == 0) ? 2'b01 : 2'b11;
        l  = (k == n - 1);
        return {d, kp, l};
    endfunction

    task automatic load_pkt(input int s, input int tag, input int n);
        for (int k = 0; k < n; k++) src_q[s].push_back(mk_beat(s, tag, k, n));
    endtask

    task automatic expect_beats(input int s, input int tag, input int n, input int count);
        for (int k = 0; k < count; k++) exp_q.push_back(mk_beat(s, tag, k, n));
    endtask

    task automatic expect_tok(input int s);
        exp_sel_q.push_back(SEL_W'(s));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_sel_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_sel_q.size() != 0) begin
            errors++;
            $display("FAIL %s: timeout with %0d beats and %0d tokens outstanding",
                     name, exp_q.size(), exp_sel_q.size());
        end
        tick();
    endtask

    task automatic wait_beats(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (beat_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, (beat_cnt >= target), 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        hs = rst ? '0 : (in_valid & in_ready);
        if (!rst && out_valid && out_ready) begin
            beat_cnt++;
            hs_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_beat: got %0h, expected nothing", {out_data, out_keep, out_last});
            end else begin
                exp_b = exp_q.pop_front();
                if ({out_data, out_keep, out_last} !== exp_b) begin
                    errors++;
                    $display("FAIL out_beat: got %0h, expected %0h", {out_data, out_keep, out_last}, exp_b);
                end
            end
        end
        if (!rst && select_valid && select_ready) begin
            checks++;
            if (exp_sel_q.size() == 0) begin
                errors++;
                $display("FAIL sel_token: got %0d, expected nothing", select_data);
            end else begin
                exp_s = exp_sel_q.pop_front();
                if (select_data !== exp_s) begin
                    errors++;
                    $display("FAIL sel_token: got %0d, expected %0d", select_data, exp_s);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int done;
        int prior;
        int n;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sel_valid", select_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        tick();

        // Single stream, 3-beat packet: exact cycle placement of beats and token.
        load_pkt(2, 1, 3);
        expect_beats(2, 1, 3, 3);
        expect_tok(2);
        rst = 1'b0;
        src_en[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t1_idle_out_valid", out_valid, 0);
        chk("t1_idle_sel_valid", select_valid, 0);
        chk("t1_idle_in_ready", in_ready, 0);
        @(negedge clk);
        chk("t1_b0_out_valid", out_valid, 1);
        chk("t1_b0_sel_valid", select_valid, 1);
        chk("t1_b0_sel_data", select_data, 2);
        chk("t1_b0_in_ready", in_ready, 4'b0100);
        @(negedge clk);
        chk("t1_b1_out_valid", out_valid, 1);
        @(negedge clk);
        chk("t1_b2_out_valid", out_valid, 1);
        chk("t1_b2_out_last", out_last, 1);
        @(negedge clk);
        chk("t1_after_out_valid", out_valid, 0);
        wait_drain("t1_drain", 50);
        src_en = '0;

        // All four streams with 1-beat packets from rr_ptr=0: order 0,1,2,3,0,1,2,3.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) begin
                load_pkt(s, 2 + r, 1);
                expect_beats(s, 2 + r, 1, 1);
                expect_tok(s);
            end
        end
        hs_cyc_q.delete();
        src_en = '1;
        wait_drain("t2_drain", 100);
        src_en = '0;
        chk("t2_beat_count", hs_cyc_q.size(), 8);
        for (int i = 1; i < hs_cyc_q.size(); i++) begin
            chk("t2_gap", hs_cyc_q[i] - hs_cyc_q[i-1], 2);
        end

        // in[1] holds the output for 4 beats; after it rr_ptr=2 so 3 beats 0.
        load_pkt(1, 4, 4);
        load_pkt(3, 5, 2);
        load_pkt(0, 6, 1);
        expect_beats(1, 4, 4, 4); expect_tok(1);
        expect_beats(3, 5, 2, 2); expect_tok(3);
        expect_beats(0, 6, 1, 1); expect_tok(0);
        src_en[1] = 1'b1;
        tick();
        src_en[0] = 1'b1;
        src_en[3] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_only_in1_ready", in_ready, 4'b0010);
        end
        wait_drain("t3_drain", 100);
        src_en = '0;

        // Token held back: packet on 2 streams, then no grant until the token is taken.
        select_ready = 1'b0;
        load_pkt(2, 7, 2);
        load_pkt(0, 8, 2);
        expect_beats(2, 7, 2, 2); expect_tok(2);
        expect_beats(0, 8, 2, 2); expect_tok(0);
        base = beat_cnt;
        src_en[2] = 1'b1;
        src_en[0] = 1'b1;
        wait_beats("t4_first_pkt", base + 2, 50);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_blocked_out_valid", out_valid, 0);
            chk("t4_pending_sel_valid", select_valid, 1);
            chk("t4_pending_sel_data", select_data, 2);
        end
        tick();
        select_ready = 1'b1;
        @(negedge clk);
        chk("t4_tok_cycle_out_valid", out_valid, 0);
        @(negedge clk);
        chk("t4_grant_cycle_sel_valid", select_valid, 0);
        chk("t4_grant_cycle_out_valid", out_valid, 0);
        @(negedge clk);
        chk("t4_next_out_valid", out_valid, 1);
        chk("t4_next_sel_valid", select_valid, 1);
        chk("t4_next_sel_data", select_data, 0);
        wait_drain("t4_drain", 50);
        src_en = '0;

        // Random backpressure on two 16-beat packets (rr_ptr=1: stream 1 then stream 0).
        load_pkt(1, 9, 16);
        load_pkt(0, 10, 16);
        expect_beats(1, 9, 16, 16); expect_tok(1);
        expect_beats(0, 10, 16, 16); expect_tok(0);
        base = beat_cnt;
        rand_ready = 1'b1;
        src_en[1] = 1'b1;
        src_en[0] = 1'b1;
        n = 0;
        done = 0;
        while (done < 32 && n < 600) begin
            @(negedge clk);
            #1;
            n++;
            done  = beat_cnt - base;
            prior = done - ((out_valid && out_ready) ? 1 : 0);
            if (out_valid) begin
                chk("t5_ready_mirror", in_ready,
                    out_ready ? ((prior < 16) ? 4'b0010 : 4'b0001) : 4'b0000);
            end
        end
        rand_ready = 1'b0;
        out_ready_fix = 1'b1;
        wait_drain("t5_drain", 100);
        src_en = '0;

        // Reset during beat 2 of a 5-beat packet; arbitration restarts from rr_ptr=0.
        load_pkt(2, 11, 5);
        expect_beats(2, 11, 5, 2);
        expect_tok(2);
        base = beat_cnt;
        src_en[2] = 1'b1;
        wait_beats("t6_two_beats", base + 2, 50);
        tick();
        rst = 1'b1;
        src_en = '0;
        src_q[2].delete();
        @(negedge clk);
        @(negedge clk);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_sel_valid", select_valid, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        load_pkt(0, 12, 1);
        load_pkt(1, 13, 1);
        expect_beats(0, 12, 1, 1); expect_tok(0);
        expect_beats(1, 13, 1, 1); expect_tok(1);
        src_en[0] = 1'b1;
        src_en[1] = 1'b1;
        wait_drain("t6_drain", 50);
        src_en = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
